// File: rtl/mux_ctrl_pkg.sv
// Shared types and constants for the basic_mux select controller.
package mux_ctrl_pkg;

  localparam int ADDR_W       = 5;
  localparam int MAX_PROJECTS = 32;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    GUARD = 2'd1,
    RESET = 2'd2,
    ON    = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pad input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Capture the pad level, then re-register it to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/mux_ctrl.sv
// Select controller for basic_mux: keeps the project address and sequences
// a guard gap plus a reset window whenever the enable or address changes.
//
//   state | meaning
//   OFF   | project disabled, held in reset
//   GUARD | enable held low while the select settles
//   RESET | project enabled but still held in reset
//   ON    | project enabled and running
module mux_ctrl
  import mux_ctrl_pkg::*;
#(
  parameter int NUM_PROJECTS = 24,
  parameter int GUARD_CYCLES = 4,
  parameter int RST_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_rst_i,
  input  logic              sel_inc_i,
  input  logic              ena_i,
  output logic [ADDR_W-1:0] addr,
  output logic              ena,
  output logic              proj_rst,
  output logic              busy
);

  localparam int MAX_CNT = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PROJECTS - 1);
  localparam logic [CNT_W-1:0]  G_LOAD    = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  R_LOAD    = CNT_W'(RST_CYCLES - 1);

  if (NUM_PROJECTS < 1 || NUM_PROJECTS > MAX_PROJECTS) begin : g_bad_num_projects
    $error("mux_ctrl: NUM_PROJECTS must be 1..32");
  end
  if (GUARD_CYCLES < 1) begin : g_bad_guard
    $error("mux_ctrl: GUARD_CYCLES must be >= 1");
  end
  if (RST_CYCLES < 1) begin : g_bad_rst
    $error("mux_ctrl: RST_CYCLES must be >= 1");
  end

  logic sel_rst_s, sel_inc_s, ena_s;
  logic sel_inc_q;
  logic inc_evt, addr_chg;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic              ena_q, ena_d;
  logic              proj_rst_q, proj_rst_d;
  logic              busy_q, busy_d;

  sync_2ff u_sync_rst (.clk(clk), .rst(rst), .d(sel_rst_i), .q(sel_rst_s));
  sync_2ff u_sync_inc (.clk(clk), .rst(rst), .d(sel_inc_i), .q(sel_inc_s));
  sync_2ff u_sync_ena (.clk(clk), .rst(rst), .d(ena_i),     .q(ena_s));

  assign inc_evt  = sel_inc_s & ~sel_inc_q;
  assign addr_chg = inc_evt | (sel_rst_s & (addr_q != '0));

  // Address update: clear wins over increment; increment wraps at the last project.
  always_comb begin
    addr_d = addr_q;
    if (sel_rst_s) begin
      addr_d = '0;
    end else if (inc_evt) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    end
  end

  // Next state, countdown and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == OFF) begin
      if (ena_s & ~sel_rst_s) begin
        state_d = GUARD;
        cnt_d   = G_LOAD;
      end
    end else if (~ena_s | sel_rst_s) begin
      state_d = OFF;
      cnt_d   = '0;
    end else if (addr_chg) begin
      // A new address always restarts the guard gap, even mid-guard.
      state_d = GUARD;
      cnt_d   = G_LOAD;
    end else begin
      case (state_q)
        GUARD: begin
          if (cnt_q == '0) begin
            state_d = RESET;
            cnt_d   = R_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RESET: begin
          if (cnt_q == '0) begin
            state_d = ON;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end

    ena_d      = (state_d == RESET) || (state_d == ON);
    proj_rst_d = (state_d != ON);
    busy_d     = (state_d == GUARD) || (state_d == RESET);
  end

  // State, counter, address and glitch-free output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      addr_q     <= '0;
      sel_inc_q  <= 1'b0;
      ena_q      <= 1'b0;
      proj_rst_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      sel_inc_q  <= sel_inc_s;
      ena_q      <= ena_d;
      proj_rst_q <= proj_rst_d;
      busy_q     <= busy_d;
    end
  end

  assign addr     = addr_q;
  assign ena      = ena_q;
  assign proj_rst = proj_rst_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mux_ctrl.sv
// Directed testbench for mux_ctrl with default parameters (24 projects, 4/8 cycles).
module tb_mux_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_rst_i, sel_inc_i, ena_i;
  logic [4:0] addr;
  logic       ena, proj_rst, busy;

  int checks = 0;
  int errors = 0;

  mux_ctrl dut (
    .clk(clk), .rst(rst),
    .sel_rst_i(sel_rst_i), .sel_inc_i(sel_inc_i), .ena_i(ena_i),
    .addr(addr), .ena(ena), .proj_rst(proj_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are read away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel_rst_i = 1'b0; sel_inc_i = 1'b0; ena_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({addr, ena, proj_rst, busy} !== {5'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got addr=%0d ena=%b proj_rst=%b busy=%b, want addr=0 ena=0 proj_rst=1 busy=0",
               addr, ena, proj_rst, busy);
    end
    rst = 1'b0;
    tick();
  endtask

  // Next edge is edge 0 and the enable request is (or becomes) clean at it.
  task automatic run_enable_seq(input string name, input logic [4:0] exp_addr);
    logic [7:0] exp;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp = {exp_addr, 1'(k >= 6), 1'(k < 14), 1'(k >= 2 && k <= 13)};
      checks++;
      if ({addr, ena, proj_rst, busy} !== exp) begin
        errors++;
        $display("FAIL %s edge %0d: got addr=%0d ena=%b proj_rst=%b busy=%b, want addr=%0d ena=%b proj_rst=%b busy=%b",
                 name, k, addr, ena, proj_rst, busy, exp[7:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_enable_seq();
    ena_i = 1'b1;
    run_enable_seq("enable_seq", 5'd0);
  endtask

  // One sel_inc pulse, checked on every edge; the address moves at edge 2.
  task automatic do_inc(input string name, input int hi, input int total,
                        input logic [4:0] prev, input logic [4:0] nxt,
                        input logic p_ena, input logic p_prst, input logic p_busy);
    logic [7:0] exp;
    for (int k = 0; k < total; k++) begin
      sel_inc_i = (k < hi);
      tick();
      if (k < 2) exp = {prev, p_ena, p_prst, p_busy};
      else       exp = {nxt, 1'(k >= 6), 1'(k < 14), 1'(k < 14)};
      checks++;
      if ({addr, ena, proj_rst, busy} !== exp) begin
        errors++;
        $display("FAIL %s edge %0d: got addr=%0d ena=%b proj_rst=%b busy=%b, want addr=%0d ena=%b proj_rst=%b busy=%b",
                 name, k, addr, ena, proj_rst, busy, exp[7:3], exp[2], exp[1], exp[0]);
      end
    end
    sel_inc_i = 1'b0;
  endtask

  task automatic quick_incs(input int n);
    for (int i = 0; i < n; i++) begin
      sel_inc_i = 1'b1; tick(); tick();
      sel_inc_i = 1'b0; tick(); tick();
    end
  endtask

  task automatic test_inc();
    do_inc("inc1", 4, 8,  5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    do_inc("inc2", 4, 8,  5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
    do_inc("inc3", 4, 16, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    quick_incs(20);
    repeat (20) tick();
    checks++;
    if ({addr, ena, proj_rst, busy} !== {5'd23, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_setup: got addr=%0d ena=%b proj_rst=%b busy=%b, want addr=23 ena=1 proj_rst=0 busy=0",
               addr, ena, proj_rst, busy);
    end
    do_inc("wrap", 4, 16, 5'd23, 5'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_hold_inc();
    do_inc("hold_inc", 50, 60, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_sel_rst();
    logic [7:0] exp;
    quick_incs(4);
    repeat (20) tick();
    checks++;
    if ({addr, ena, proj_rst, busy} !== {5'd5, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sel_rst_setup: got addr=%0d ena=%b proj_rst=%b busy=%b, want addr=5 ena=1 proj_rst=0 busy=0",
               addr, ena, proj_rst, busy);
    end
    sel_rst_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp = (k < 2) ? {5'd5, 1'b1, 1'b0, 1'b0} : {5'd0, 1'b0, 1'b1, 1'b0};
      checks++;
      if ({addr, ena, proj_rst, busy} !== exp) begin
        errors++;
        $display("FAIL sel_rst edge %0d: got addr=%0d ena=%b proj_rst=%b busy=%b, want addr=%0d ena=%b proj_rst=%b busy=%b",
                 k, addr, ena, proj_rst, busy, exp[7:3], exp[2], exp[1], exp[0]);
      end
    end
    sel_rst_i = 1'b0;
    run_enable_seq("sel_rst_release", 5'd0);
  endtask

  task automatic test_ena_low();
    logic [7:0] exp;
    ena_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = (k < 2) ? {5'd0, 1'b1, 1'b0, 1'b0} : {5'd0, 1'b0, 1'b1, 1'b0};
      checks++;
      if ({addr, ena, proj_rst, busy} !== exp) begin
        errors++;
        $display("FAIL ena_low edge %0d: got addr=%0d ena=%b proj_rst=%b busy=%b, want addr=%0d ena=%b proj_rst=%b busy=%b",
                 k, addr, ena, proj_rst, busy, exp[7:3], exp[2], exp[1], exp[0]);
      end
    end
    ena_i = 1'b1;
    run_enable_seq("ena_reenable", 5'd0);
  endtask

  task automatic test_rst_abort();
    quick_incs(7);
    repeat (4) tick();
    checks++;
    if ({addr, ena, proj_rst, busy} !== {5'd7, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL abort_setup: got addr=%0d ena=%b proj_rst=%b busy=%b, want addr=7 ena=1 proj_rst=1 busy=1",
               addr, ena, proj_rst, busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({addr, ena, proj_rst, busy} !== {5'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset: got addr=%0d ena=%b proj_rst=%b busy=%b, want addr=0 ena=0 proj_rst=1 busy=0",
               addr, ena, proj_rst, busy);
    end
    rst = 1'b0;
    run_enable_seq("abort_restart", 5'd0);
  endtask

  initial begin
    test_reset();
    test_enable_seq();
    test_inc();
    test_wrap();
    test_hold_inc();
    test_sel_rst();
    test_ena_low();
    test_rst_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
